reg_native_if2apb_bridge: RTL

Parametrised bridge from the register native request/ack interface to an APB4 requester port.
- Latches one native request, runs a full APB SETUP/ACCESS sequence and honours PREADY wait states.
- Returns a registered one-cycle ack with read data and error status.
- Sits between the register-block native master and APB-attached register slaves.
- Successor to the fixed-width bridge: adds width parameters, request flow control, PSTRB/PSLVERR and illegal-command detection.

---
 rtl/reg_native_if2apb_bridge.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/reg_native_if2apb_bridge.sv
// reg_native_if2apb_bridge
// Bridges the register-block native request/ack interface onto an APB4
// requester port. One request is latched at a time, a full SETUP/ACCESS
// sequence is run on APB (PREADY wait states are honoured), and a registered
// one-cycle ack returns the read data and error status.
//
// Optional build macro: REG_NATIVE_IF2APB_BRIDGE_TIMEOUT_EN
//   When defined, an ACCESS phase that sees no PREADY for TIMEOUT_CYCLES
//   cycles is abandoned and completed with err=1, rd_data=0.
//   When undefined, ACCESS waits for PREADY indefinitely.

module reg_native_if2apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,

    // Native request side
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,

    // Native completion side
    output logic                  ack_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err,

    // APB4 requester port
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    // Elaboration-time sanity checks on the configuration.
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("reg_native_if2apb_bridge: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("reg_native_if2apb_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end
    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("reg_native_if2apb_bridge: ADDR_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q,  strb_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q,   err_d;

    // A legal command has exactly one of wr_en / rd_en set.
    logic cmd_legal;
    assign cmd_legal = wr_en ^ rd_en;

`ifdef REG_NATIVE_IF2APB_BRIDGE_TIMEOUT_EN
    // The counter holds the number of PREADY-less ACCESS cycles already seen;
    // the timeout fires in the cycle that would make it reach TIMEOUT_CYCLES.
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        timeout_hit;

    assign timeout_hit = (state_q == ST_ACCESS) && !PREADY && (cnt_q == CNT_LIMIT);
`endif

    // State register; reset abandons any transfer in flight without an ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: illegal commands skip the APB phases entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    state_d = cmd_legal ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d = ST_RESP;
                end
`ifdef REG_NATIVE_IF2APB_BRIDGE_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: handshake and APB controls come straight from state,
    // everything else from the latched registers.
    always_comb begin
        req_rdy = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        ack_vld = 1'b0;
        case (state_q)
            ST_IDLE:   req_rdy = 1'b1;
            ST_SETUP:  PSEL    = 1'b1;
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            ST_RESP:   ack_vld = 1'b1;
            default:   req_rdy = 1'b0;
        endcase
        PWRITE  = write_q;
        PADDR   = addr_q;
        PWDATA  = wdata_q;
        PSTRB   = write_q ? strb_q : '0;
        rd_data = rdata_q;
        err     = err_q;
    end

    // Datapath next values: latch the request on accept, capture the
    // response when the slave completes (or on an illegal command).
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    addr_d  = addr;
                    wdata_d = wr_data;
                    strb_d  = wr_strb;
                    write_d = wr_en;
                    if (!cmd_legal) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rdata_d = write_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                end
`ifdef REG_NATIVE_IF2APB_BRIDGE_TIMEOUT_EN
                else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
`endif
            end
            default: begin
                rdata_d = rdata_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef REG_NATIVE_IF2APB_BRIDGE_TIMEOUT_EN
    // Wait-state counter: cleared while in SETUP so it starts at zero on
    // entry to ACCESS, then counts ACCESS cycles without PREADY.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_SETUP) begin
            cnt_d = '0;
        end else if (state_q == ST_ACCESS && !PREADY && !timeout_hit) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Wait-state counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule
